// File: rtl/pipelined_add_sub_pkg.sv
// pipelined_add_sub_pkg: mode encodings and {N,Z,V,C} flag order shared with the writeback block
package pipelined_add_sub_pkg;
  typedef enum logic {MODE_ADD = 1'b0, MODE_SUB = 1'b1} mode_t;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;
  function automatic logic [3:0] pack_flags(input logic n, input logic z, input logic v, input logic c);
    return {n, z, v, c};
  endfunction
endpackage

// File: rtl/pipelined_add_sub_slice.sv
// add_sub_slice: CHUNK-bit combinational add/sub slice; a,b,m,ci in -> s, co, c_msb (carry into top bit) out
module add_sub_slice
  import pipelined_add_sub_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             m,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [CHUNK-1:0] bx;
  always_comb begin
    bx = b ^ {CHUNK{m == MODE_SUB}};
    {co, s} = {1'b0, a} + {1'b0, bx} + {{CHUNK{1'b0}}, ci};
    c_msb = s[CHUNK-1] ^ a[CHUNK-1] ^ bx[CHUNK-1];
  end
endmodule

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: WIDTH-bit add/sub in WIDTH/CHUNK registered slices; in_valid/in_ready/A/B/M/Cin in, out_valid/out_ready, S/Cout/V/N/Z out
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             N,
  output logic             Z
);
  localparam int STAGES = WIDTH / CHUNK;
  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             cm;
    logic             z;
    logic             m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;
  stage_t st [STAGES];
  stage_t in_st;
  logic adv;
  assign out_valid = st[STAGES-1].v;
  assign adv = !out_valid | out_ready;
  assign in_ready = adv;
  assign in_st = '{v: in_valid, res: '0, c: (M == MODE_SUB) ? ~Cin : Cin, cm: 1'b0, z: 1'b1, m: M, a: A, b: B};
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t src, nxt;
    logic [CHUNK-1:0] s;
    logic co, cm;
    if (k == 0) begin : g_first
      assign src = in_st;
    end else begin : g_next
      assign src = st[k-1];
    end
    add_sub_slice #(.CHUNK(CHUNK)) u_slice (
      .a(src.a[k*CHUNK +: CHUNK]), .b(src.b[k*CHUNK +: CHUNK]), .m(src.m), .ci(src.c),
      .s(s), .co(co), .c_msb(cm)
    );
    always_comb begin
      nxt = src;
      nxt.res[k*CHUNK +: CHUNK] = s;
      nxt.c = co;
      nxt.cm = cm;
      nxt.z = src.z & (s == '0);
    end
    always_ff @(posedge clk) begin
      if (rst) st[k] <= '0;
      else if (adv) st[k] <= nxt;
    end
  end
  assign S = st[STAGES-1].res;
  assign Cout = st[STAGES-1].c;
  assign V = st[STAGES-1].cm ^ st[STAGES-1].c;
  assign N = st[STAGES-1].res[WIDTH-1];
  assign Z = st[STAGES-1].z;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed self-checking bench for pipelined_add_sub at WIDTH=16, CHUNK=4
module tb_pipelined_add_sub;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, m = 0, cin = 0, out_valid, out_ready = 1;
  logic [15:0] a = '0, b = '0, s;
  logic cout, v, n, z;
  int total = 0, bad = 0;
  logic [19:0] exp_q[$], got_q[$];
  pipelined_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b), .M(m), .Cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .S(s), .Cout(cout), .V(v), .N(n), .Z(z)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!rst && out_valid && out_ready) got_q.push_back({s, n, z, v, cout});
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [15:0] ta, input logic [15:0] tb2, input logic tm, input logic tc,
                      input logic [15:0] es, input logic [3:0] ef, input bit keep);
    int g;
    logic r;
    a = ta; b = tb2; m = tm; cin = tc; in_valid = 1; g = 0;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      g++;
    end while (!r && g < 200);
    if (!r) chk("send_timeout", 0, 1);
    in_valid = 0;
    if (keep) exp_q.push_back({es, ef});
  endtask
  task automatic drain(input string tag);
    int g;
    g = 0;
    while (got_q.size() < exp_q.size() && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++)
      chk($sformatf("%s_%0d", tag, i), got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_state", {out_valid, s, cout, v, n, z}, '0);
    rst = 0;
    send(16'h1234, 16'h0FED, 0, 0, 16'h2221, 4'b0000, 1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency_add", lat, 4);
    drain("add");
    send(16'h8000, 16'h8000, 1, 0, 16'h0000, 4'b0101, 1);
    send(16'h0001, 16'h0002, 1, 0, 16'hFFFF, 4'b1000, 1);
    send(16'h0005, 16'h0003, 1, 1, 16'h0001, 4'b0001, 1);
    drain("sub");
    send(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 4'b1010, 1);
    send(16'h8000, 16'h0001, 1, 0, 16'h7FFF, 4'b0011, 1);
    send(16'hFFFF, 16'h0000, 0, 1, 16'h0000, 4'b0101, 1);
    drain("ovf_ripple");
    fork
      begin
        send(16'h0001, 16'h0001, 0, 0, 16'h0002, 4'b0000, 1);
        send(16'h00FF, 16'h0001, 0, 0, 16'h0100, 4'b0000, 1);
        send(16'h0FFF, 16'h0001, 0, 0, 16'h1000, 4'b0000, 1);
        send(16'h1234, 16'h4321, 0, 0, 16'h5555, 4'b0000, 1);
        send(16'hAAAA, 16'h5555, 0, 0, 16'hFFFF, 4'b1000, 1);
        send(16'hFFFE, 16'h0003, 0, 0, 16'h0001, 4'b0001, 1);
        send(16'h4000, 16'h4000, 0, 0, 16'h8000, 4'b1010, 1);
        send(16'h0000, 16'h0000, 0, 0, 16'h0000, 4'b0100, 1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk($sformatf("bp_in_ready_%0d", i), in_ready, 0);
          chk($sformatf("bp_valid_%0d", i), out_valid, 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1;
      end
    join
    drain("bp");
    send(16'h0010, 16'h0001, 0, 0, 16'h0011, 4'b0000, 0);
    send(16'h0020, 16'h0002, 0, 0, 16'h0022, 4'b0000, 0);
    send(16'h0030, 16'h0003, 0, 0, 16'h0033, 4'b0000, 0);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rst_flush_%0d", i), out_valid, 0);
      @(posedge clk);
      #1;
    end
    send(16'h0005, 16'h0003, 1, 1, 16'h0001, 4'b0001, 1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency_after_rst", lat, 4);
    drain("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
